// File: rtl/nes_pkg.sv
// nes_pkg: shared state, button index and button vector types for the NES reader
package nes_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_HI, SHIFT_LO, DONE} nes_state_t;
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } nes_btn_t;
  typedef logic [7:0] nes_buttons_t;
endpackage

// File: rtl/nes_phase_timer.sv
// nes_phase_timer: half-period down-counter, reloads on i_load, o_expire marks the last cycle of a phase
module nes_phase_timer #(
  parameter int TICK_DIV = 600
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_expire
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LOAD = W'(TICK_DIV - 1);
  logic [W-1:0] r_cnt;
  // counts down D cycles from each load and parks at zero
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/nes_controller_reader.sv
// nes_controller_reader: polls an NES pad (latch + 7 clock pulses) and reports 8 active-high button flags
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int TICK_DIV    = 600,
  parameter int POLL_CYCLES = 1666667,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);
  localparam int PW = POLL_CYCLES > 1 ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LOAD = POLL_CYCLES > 0 ? PW'(POLL_CYCLES - 1) : '0;
  logic [1:0]    r_sync;
  nes_state_t    r_state;
  logic          r_half;
  logic [2:0]    r_bit;
  nes_buttons_t  r_shift;
  logic [PW-1:0] r_poll;
  logic          w_expire, w_auto, w_start, w_load, w_sample;
  assign w_sample = ACTIVE_LOW != 0 ? ~r_sync[1] : r_sync[1];
  assign w_auto   = (POLL_CYCLES != 0) && (r_poll == '0);
  assign w_start  = (r_state == IDLE) && (poll_req || w_auto);
  assign w_load   = w_start || (w_expire && busy);
  nes_phase_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .o_expire(w_expire)
  );
  // two-flop synchronizer for the pad's serial line
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sync <= '0;
    else r_sync <= {r_sync[0], data};
  // auto-poll countdown; a zero count stays pending until the FSM is idle
  always_ff @(posedge clk or posedge reset)
    if (reset) r_poll <= POLL_LOAD;
    else if (w_start) r_poll <= POLL_LOAD;
    else if (r_poll != '0) r_poll <= r_poll - 1'b1;
  // frame sequencer: two latch phases, then seven high/low clock pulses, each sample taken at a phase end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      r_half    <= 1'b0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state   <= LATCH;
          nes_latch <= 1'b1;
          busy      <= 1'b1;
          r_half    <= 1'b0;
        end
        LATCH: if (w_expire) begin
          r_half <= 1'b1;
          if (r_half) begin
            r_shift[BTN_A] <= w_sample;
            r_bit          <= BTN_B;
            nes_latch      <= 1'b0;
            nes_clk        <= 1'b1;
            r_state        <= SHIFT_HI;
          end
        end
        SHIFT_HI: if (w_expire) begin
          r_shift[r_bit] <= w_sample;
          nes_clk        <= 1'b0;
          r_state        <= SHIFT_LO;
        end
        SHIFT_LO: if (w_expire) begin
          if (r_bit == BTN_RIGHT) begin
            r_state <= DONE;
            buttons <= r_shift;
            valid   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_bit   <= r_bit + 1'b1;
            nes_clk <= 1'b1;
            r_state <= SHIFT_HI;
          end
        end
        DONE: begin
          valid   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
